// File: rtl/fetch_ifid_if.sv
// Instruction-memory port between the fetch stage (master) and a combinational-read
// instruction memory (slave). No valid/ready: the read completes in the same cycle.
interface fetch_ifid_if #(
    parameter int IMEM_AW = 6
);
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_data;

    modport master (output imem_addr, input imem_data);
    modport slave  (input imem_addr, output imem_data);
endinterface

// File: rtl/fetch_ifid.sv
// LEGv8 instruction fetch plus IF/ID pipeline register with stall, flush and branch redirect.
// Optional macro FETCH_PERF_CNT_EN adds fetch_cnt / bubble_cnt performance counters.
module fetch_ifid #(
    parameter int             N        = 64,
    parameter logic [N-1:0]   RESET_PC = '0,
    parameter int             IMEM_AW  = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall_D,
    input  logic               flush_D,
    input  logic               PCSrc_D,
    input  logic [N-1:0]       PCBranch_D,
    fetch_ifid_if.master       imem,
    output logic [N-1:0]       pc_F,
    output logic [31:0]        instr_D,
    output logic [N-1:0]       pc_D,
    output logic               valid_D
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        fetch_cnt,
    output logic [31:0]        bubble_cnt
`endif
);

    localparam logic [N-1:0] PC_STEP = N'(4);

    logic [N-1:0] pc_fetch_q, pc_fetch_d;
    logic [31:0]  instr_id_q, instr_id_d;
    logic [N-1:0] pc_id_q, pc_id_d;
    logic         valid_id_q, valid_id_d;
    logic         load_bubble, load_valid;

    always_comb begin
        load_bubble = flush_D | PCSrc_D;
        load_valid  = !load_bubble && !stall_D;

        // A taken branch redirects the PC even while decode is stalled.
        pc_fetch_d = pc_fetch_q;
        if (PCSrc_D) begin
            pc_fetch_d = PCBranch_D;
        end else if (!stall_D) begin
            pc_fetch_d = pc_fetch_q + PC_STEP;
        end

        instr_id_d = instr_id_q;
        pc_id_d    = pc_id_q;
        valid_id_d = valid_id_q;
        if (load_bubble) begin
            instr_id_d = 32'h0;
            pc_id_d    = '0;
            valid_id_d = 1'b0;
        end else if (load_valid) begin
            instr_id_d = imem.imem_data;
            pc_id_d    = pc_fetch_q;
            valid_id_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_fetch_q <= RESET_PC;
            instr_id_q <= 32'h0;
            pc_id_q    <= '0;
            valid_id_q <= 1'b0;
        end else begin
            pc_fetch_q <= pc_fetch_d;
            instr_id_q <= instr_id_d;
            pc_id_q    <= pc_id_d;
            valid_id_q <= valid_id_d;
        end
    end

    // Upper PC bits are dropped, so the instruction memory aliases.
    assign imem.imem_addr = pc_fetch_q[IMEM_AW+1:2];
    assign pc_F           = pc_fetch_q;
    assign instr_D        = instr_id_q;
    assign pc_D           = pc_id_q;
    assign valid_D        = valid_id_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        fetch_cnt_d  = fetch_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (load_valid) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if (load_bubble) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_cnt_q  <= 32'h0;
            bubble_cnt_q <= 32'h0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign fetch_cnt  = fetch_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_ifid.sv
// Self-checking bench for fetch_ifid: reference PC / IF/ID model feeding an expected queue.
module tb_fetch_ifid;
  localparam int N = 64;
  localparam int IMEM_AW = 6;
  localparam int W = N + 32 + 1;

  logic clk;
  logic reset;
  logic stall_D, flush_D, PCSrc_D;
  logic [N-1:0] PCBranch_D;
  logic [N-1:0] pc_F, pc_D;
  logic [31:0] instr_D;
  logic valid_D;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt, bubble_cnt;
`endif

  logic [31:0] mem [0:(1<<IMEM_AW)-1];

  fetch_ifid_if #(.IMEM_AW(IMEM_AW)) bus ();
  assign bus.imem_data = mem[bus.imem_addr];

  fetch_ifid #(.N(N), .RESET_PC('0), .IMEM_AW(IMEM_AW)) dut (
    .clk(clk),
    .reset(reset),
    .stall_D(stall_D),
    .flush_D(flush_D),
    .PCSrc_D(PCSrc_D),
    .PCBranch_D(PCBranch_D),
    .imem(bus),
    .pc_F(pc_F),
    .instr_D(instr_D),
    .pc_D(pc_D),
    .valid_D(valid_D)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt(fetch_cnt),
    .bubble_cnt(bubble_cnt)
`endif
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;

  // scoreboard: {pc_D, instr_D, valid_D} expected after each driven edge
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_v;
  logic [W-1:0] m_ifid;
  logic [N-1:0] m_pc;
  logic [31:0] m_fetch, m_bubble;

  // driver: one clock edge with given controls; model updated and expectation queued
  task automatic drive_cycle(input logic st, input logic fl, input logic br, input logic [N-1:0] tgt);
    logic [N-1:0] pc_old;
    stall_D = st;
    flush_D = fl;
    PCSrc_D = br;
    PCBranch_D = tgt;
    pc_old = m_pc;
    if (br) m_pc = tgt;
    else if (!st) m_pc = m_pc + 64'd4;
    if (fl || br) begin
      m_ifid = '0;
      m_bubble = m_bubble + 32'd1;
    end else if (!st) begin
      m_ifid = {pc_old, mem[pc_old[IMEM_AW+1:2]], 1'b1};
      m_fetch = m_fetch + 32'd1;
    end
    exp_q.push_back(m_ifid);
    @(posedge clk);
    #1;
    stall_D = 1'b0;
    flush_D = 1'b0;
    PCSrc_D = 1'b0;
    PCBranch_D = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    m_pc = '0;
    m_ifid = '0;
    m_fetch = '0;
    m_bubble = '0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (pc_F !== 64'h0) begin n_errors++; $display("FAIL reset_pc: got %h want 0", pc_F); end
    n_checks++;
    if (valid_D !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", valid_D); end
    n_checks++;
    if (instr_D !== 32'h0) begin n_errors++; $display("FAIL reset_instr: got %h want 0", instr_D); end
`ifdef FETCH_PERF_CNT_EN
    n_checks++;
    if (fetch_cnt !== 32'h0 || bubble_cnt !== 32'h0) begin
      n_errors++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", fetch_cnt, bubble_cnt);
    end
`endif
    reset = 1'b1;
    drive_cycle(1'b0, 1'b0, 1'b0, '0);
    n_checks++;
    if (pc_F !== 64'h4) begin n_errors++; $display("FAIL first_pc: got %h want 4", pc_F); end
    exp_v = exp_q.pop_front();
    n_checks++;
    if ({pc_D, instr_D, valid_D} !== exp_v || instr_D !== mem[0] || valid_D !== 1'b1) begin
      n_errors++; $display("FAIL first_fetch: got %h want %h", {pc_D, instr_D, valid_D}, exp_v);
    end
  endtask

  task automatic test_sequential();
    do_reset();
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b0, 1'b0, 1'b0, '0);
      exp_v = exp_q.pop_front();
      n_checks++;
      if ({pc_D, instr_D, valid_D} !== exp_v || pc_D !== 64'(i * 4)) begin
        n_errors++; $display("FAIL seq_ifid[%0d]: got %h want %h", i, {pc_D, instr_D, valid_D}, exp_v);
      end
      n_checks++;
      if (pc_F !== m_pc) begin n_errors++; $display("FAIL seq_pc[%0d]: got %h want %h", i, pc_F, m_pc); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    reset = 1'b1;
    repeat (3) begin
      drive_cycle(1'b0, 1'b0, 1'b0, '0);
      void'(exp_q.pop_front());
    end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 1'b0, 1'b0, '0);
      n_checks++;
      if (pc_F !== 64'd12) begin n_errors++; $display("FAIL stall_pc[%0d]: got %h want c", i, pc_F); end
      exp_v = exp_q.pop_front();
      n_checks++;
      if ({pc_D, instr_D, valid_D} !== exp_v || pc_D !== 64'd8) begin
        n_errors++; $display("FAIL stall_ifid[%0d]: got %h want %h", i, {pc_D, instr_D, valid_D}, exp_v);
      end
    end
    drive_cycle(1'b0, 1'b0, 1'b0, '0);
    n_checks++;
    if (pc_F !== 64'd16) begin n_errors++; $display("FAIL stall_release_pc: got %h want 10", pc_F); end
    exp_v = exp_q.pop_front();
    n_checks++;
    if ({pc_D, instr_D, valid_D} !== exp_v) begin
      n_errors++; $display("FAIL stall_release_ifid: got %h want %h", {pc_D, instr_D, valid_D}, exp_v);
    end
  endtask

  task automatic test_branch();
    drive_cycle(1'b1, 1'b0, 1'b1, 64'h40);
    n_checks++;
    if (pc_F !== 64'h40) begin n_errors++; $display("FAIL branch_pc: got %h want 40", pc_F); end
    exp_v = exp_q.pop_front();
    n_checks++;
    if (valid_D !== 1'b0 || instr_D !== 32'h0 || {pc_D, instr_D, valid_D} !== exp_v) begin
      n_errors++; $display("FAIL branch_bubble: got %h want %h", {pc_D, instr_D, valid_D}, exp_v);
    end
    drive_cycle(1'b0, 1'b0, 1'b0, '0);
    exp_v = exp_q.pop_front();
    n_checks++;
    if (instr_D !== mem[16] || pc_D !== 64'h40 || {pc_D, instr_D, valid_D} !== exp_v) begin
      n_errors++; $display("FAIL branch_target: got %h want %h", {pc_D, instr_D, valid_D}, exp_v);
    end
  endtask

  task automatic test_flush_reset();
    logic [N-1:0] pc_hold;
    pc_hold = m_pc;
    drive_cycle(1'b1, 1'b1, 1'b0, '0);
    n_checks++;
    if (pc_F !== pc_hold) begin n_errors++; $display("FAIL flush_stall_pc: got %h want %h", pc_F, pc_hold); end
    exp_v = exp_q.pop_front();
    n_checks++;
    if ({pc_D, instr_D, valid_D} !== exp_v || valid_D !== 1'b0) begin
      n_errors++; $display("FAIL flush_stall_ifid: got %h want %h", {pc_D, instr_D, valid_D}, exp_v);
    end
    drive_cycle(1'b0, 1'b0, 1'b0, '0);
    void'(exp_q.pop_front());
    reset = 1'b0;
    PCSrc_D = 1'b1;
    PCBranch_D = 64'h80;
    flush_D = 1'b1;
    @(posedge clk);
    #1;
    PCSrc_D = 1'b0;
    PCBranch_D = '0;
    flush_D = 1'b0;
    n_checks++;
    if (pc_F !== 64'h0) begin n_errors++; $display("FAIL reset_over_branch_pc: got %h want 0", pc_F); end
    n_checks++;
    if (valid_D !== 1'b0 || instr_D !== 32'h0 || pc_D !== 64'h0) begin
      n_errors++; $display("FAIL reset_over_branch_ifid: got %h want 0", {pc_D, instr_D, valid_D});
    end
    m_pc = '0;
    m_ifid = '0;
    m_fetch = '0;
    m_bubble = '0;
    exp_q.delete();
    reset = 1'b1;
  endtask

  task automatic test_wrap_alias();
    drive_cycle(1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    void'(exp_q.pop_front());
    n_checks++;
    if (bus.imem_addr !== 6'h3F) begin n_errors++; $display("FAIL alias_addr: got %h want 3f", bus.imem_addr); end
    drive_cycle(1'b0, 1'b0, 1'b0, '0);
    n_checks++;
    if (pc_F !== 64'h0) begin n_errors++; $display("FAIL wrap_pc: got %h want 0", pc_F); end
    exp_v = exp_q.pop_front();
    n_checks++;
    if ({pc_D, instr_D, valid_D} !== exp_v || instr_D !== mem[63]) begin
      n_errors++; $display("FAIL wrap_ifid: got %h want %h", {pc_D, instr_D, valid_D}, exp_v);
    end
  endtask

  task automatic test_random_mix();
    logic st, fl, br;
    for (int i = 0; i < 40; i++) begin
      st = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 5) == 0);
      br = ($urandom_range(0, 6) == 0);
      drive_cycle(st, fl, br, {56'h0, 6'($urandom_range(0, 63)), 2'b00});
      exp_v = exp_q.pop_front();
      n_checks++;
      if ({pc_D, instr_D, valid_D} !== exp_v || pc_F !== m_pc) begin
        n_errors++; $display("FAIL mix[%0d]: got %h/%h want %h/%h", i, {pc_D, instr_D, valid_D}, pc_F, exp_v, m_pc);
      end
    end
`ifdef FETCH_PERF_CNT_EN
    n_checks++;
    if (fetch_cnt !== m_fetch || bubble_cnt !== m_bubble) begin
      n_errors++; $display("FAIL mix_cnt: got %0d/%0d want %0d/%0d", fetch_cnt, bubble_cnt, m_fetch, m_bubble);
    end
`endif
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf_cnt();
    do_reset();
    reset = 1'b1;
    drive_cycle(1'b1, 1'b0, 1'b1, 64'h40);
    repeat (4) drive_cycle(1'b0, 1'b0, 1'b0, '0);
    exp_q.delete();
    n_checks++;
    if (bubble_cnt !== 32'd1) begin n_errors++; $display("FAIL perf_bubble: got %0d want 1", bubble_cnt); end
    n_checks++;
    if (fetch_cnt !== 32'd4) begin n_errors++; $display("FAIL perf_fetch: got %0d want 4", fetch_cnt); end
    drive_cycle(1'b1, 1'b0, 1'b0, '0);
    exp_q.delete();
    n_checks++;
    if (fetch_cnt !== 32'd4 || bubble_cnt !== 32'd1) begin
      n_errors++; $display("FAIL perf_stall: got %0d/%0d want 4/1", fetch_cnt, bubble_cnt);
    end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b0;
    stall_D = 1'b0;
    flush_D = 1'b0;
    PCSrc_D = 1'b0;
    PCBranch_D = '0;
    m_pc = '0;
    m_ifid = '0;
    m_fetch = '0;
    m_bubble = '0;
    for (int i = 0; i < (1 << IMEM_AW); i++) mem[i] = $urandom() | 32'h1;
    #1;
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_flush_reset();
    test_wrap_alias();
    test_random_mix();
`ifdef FETCH_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
